// File: rtl/chip8_alu_unit.sv
// Multi-cycle execute unit for CHIP-8 register-class instructions (3/4/5/6/7/8/9 groups).
// Vx/Vy/VF traffic goes through a valid/ready request port with a separate read-return strobe.
module chip8_alu_unit #(
  parameter int DATA_W         = 8,
  parameter int REG_ADDR_W     = 5,
  parameter int FLAG_REG       = 15,
  parameter int QUIRK_SHIFT_VY = 0,
  parameter int QUIRK_VF_RESET = 0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic [15:0]           opcode_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  skip_out,
  output logic                  error_out,
  output logic [REG_ADDR_W-1:0] reg_addr_out,
  output logic                  reg_we_out,
  output logic                  reg_valid_out,
  output logic [DATA_W-1:0]     reg_data_out,
  input  logic                  reg_ready_in,
  input  logic                  reg_valid_in,
  input  logic [DATA_W-1:0]     reg_data_in
);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_DECODE = 4'd1,
    ST_REQ_X  = 4'd2,
    ST_WAIT_X = 4'd3,
    ST_REQ_Y  = 4'd4,
    ST_WAIT_Y = 4'd5,
    ST_WR_RES = 4'd6,
    ST_WR_VF  = 4'd7,
    ST_DONE   = 4'd8
  } state_t;

  localparam logic [REG_ADDR_W-1:0] VF_ADDR = REG_ADDR_W'(FLAG_REG);

  function automatic logic op_supported(input logic [15:0] op);
    logic ok;
    case (op[15:12])
      4'h3, 4'h4, 4'h6, 4'h7: ok = 1'b1;
      4'h5, 4'h9:             ok = (op[3:0] == 4'h0);
      4'h8:                   ok = (op[3:0] <= 4'h7) || (op[3:0] == 4'hE);
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic op_needs_vf(input logic [15:0] op);
    logic need;
    case (op[3:0])
      4'h4, 4'h5, 4'h6, 4'h7, 4'hE: need = 1'b1;
      4'h1, 4'h2, 4'h3:             need = (QUIRK_VF_RESET != 0);
      default:                      need = 1'b0;
    endcase
    return need && (op[15:12] == 4'h8);
  endfunction

  state_t                  state_r, state_nxt_s;
  logic [15:0]             op_r;
  logic [DATA_W-1:0]       vx_r, vy_r;
  logic [3:0]              op_hi_s, op_lo_s;
  logic [REG_ADDR_W-1:0]   x_addr_s, y_addr_s;
  logic [DATA_W-1:0]       kk_s, cur_vx_s, cur_vy_s, src_s;
  logic [DATA_W:0]         sum_s;
  logic [DATA_W-1:0]       alu_res_s;
  logic                    alu_flag_s, alu_skip_s;
  logic                    busy_nxt_s, done_nxt_s, skip_nxt_s, error_nxt_s;
  logic                    valid_nxt_s, we_nxt_s;
  logic [REG_ADDR_W-1:0]   addr_nxt_s;
  logic [DATA_W-1:0]       data_nxt_s;

  assign op_hi_s  = op_r[15:12];
  assign op_lo_s  = op_r[3:0];
  assign x_addr_s = REG_ADDR_W'(op_r[11:8]);
  assign y_addr_s = REG_ADDR_W'(op_r[7:4]);
  assign kk_s     = DATA_W'(op_r[7:0]);
  // Operands are bypassed from the return bus on the capture cycle so the result is ready on entry to WR_RES.
  assign cur_vx_s = (state_r == ST_WAIT_X) ? reg_data_in : vx_r;
  assign cur_vy_s = (state_r == ST_WAIT_Y) ? reg_data_in : vy_r;
  assign src_s    = (QUIRK_SHIFT_VY != 0) ? cur_vy_s : cur_vx_s;
  assign sum_s    = {1'b0, cur_vx_s} + {1'b0, cur_vy_s};

  // State register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Opcode latch and operand capture
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      op_r <= 16'h0000;
      vx_r <= {DATA_W{1'b0}};
      vy_r <= {DATA_W{1'b0}};
    end else begin
      if (state_r == ST_IDLE && start_in) begin
        op_r <= opcode_in;
      end
      if (state_r == ST_WAIT_X && reg_valid_in) begin
        vx_r <= reg_data_in;
      end
      if (state_r == ST_WAIT_Y && reg_valid_in) begin
        vy_r <= reg_data_in;
      end
    end
  end

  // Result, flag and skip evaluation
  always_comb begin
    alu_res_s  = {DATA_W{1'b0}};
    alu_flag_s = 1'b0;
    alu_skip_s = 1'b0;
    case (op_hi_s)
      4'h3: alu_skip_s = (cur_vx_s == kk_s);
      4'h4: alu_skip_s = (cur_vx_s != kk_s);
      4'h5: alu_skip_s = (cur_vx_s == cur_vy_s);
      4'h9: alu_skip_s = (cur_vx_s != cur_vy_s);
      4'h6: alu_res_s  = kk_s;
      4'h7: alu_res_s  = cur_vx_s + kk_s;
      4'h8: begin
        case (op_lo_s)
          4'h0: alu_res_s = cur_vy_s;
          4'h1: alu_res_s = cur_vx_s | cur_vy_s;
          4'h2: alu_res_s = cur_vx_s & cur_vy_s;
          4'h3: alu_res_s = cur_vx_s ^ cur_vy_s;
          4'h4: begin
            alu_res_s  = sum_s[DATA_W-1:0];
            alu_flag_s = sum_s[DATA_W];
          end
          4'h5: begin
            alu_res_s  = cur_vx_s - cur_vy_s;
            alu_flag_s = (cur_vx_s >= cur_vy_s);
          end
          4'h6: begin
            alu_res_s  = {1'b0, src_s[DATA_W-1:1]};
            alu_flag_s = src_s[0];
          end
          4'h7: begin
            alu_res_s  = cur_vy_s - cur_vx_s;
            alu_flag_s = (cur_vy_s >= cur_vx_s);
          end
          4'hE: begin
            alu_res_s  = {src_s[DATA_W-2:0], 1'b0};
            alu_flag_s = src_s[DATA_W-1];
          end
          default: alu_res_s = {DATA_W{1'b0}};
        endcase
      end
      default: alu_res_s = {DATA_W{1'b0}};
    endcase
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!start_in) state_nxt_s = ST_IDLE;
        else if (op_supported(opcode_in)) state_nxt_s = ST_DECODE;
        else state_nxt_s = ST_DONE;
      end
      ST_DECODE: begin
        if (op_hi_s == 4'h6) state_nxt_s = ST_WR_RES;
        else state_nxt_s = ST_REQ_X;
      end
      ST_REQ_X: begin
        if (reg_ready_in) state_nxt_s = ST_WAIT_X;
        else state_nxt_s = ST_REQ_X;
      end
      ST_WAIT_X: begin
        if (!reg_valid_in) state_nxt_s = ST_WAIT_X;
        else if (op_hi_s == 4'h7) state_nxt_s = ST_WR_RES;
        else if (op_hi_s == 4'h3 || op_hi_s == 4'h4) state_nxt_s = ST_DONE;
        else state_nxt_s = ST_REQ_Y;
      end
      ST_REQ_Y: begin
        if (reg_ready_in) state_nxt_s = ST_WAIT_Y;
        else state_nxt_s = ST_REQ_Y;
      end
      ST_WAIT_Y: begin
        if (!reg_valid_in) state_nxt_s = ST_WAIT_Y;
        else if (op_hi_s == 4'h8) state_nxt_s = ST_WR_RES;
        else state_nxt_s = ST_DONE;
      end
      ST_WR_RES: begin
        if (!reg_ready_in) state_nxt_s = ST_WR_RES;
        else if (op_needs_vf(op_r)) state_nxt_s = ST_WR_VF;
        else state_nxt_s = ST_DONE;
      end
      ST_WR_VF: begin
        if (reg_ready_in) state_nxt_s = ST_DONE;
        else state_nxt_s = ST_WR_VF;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output values for the upcoming state; held values stay stable while a request stalls
  always_comb begin
    busy_nxt_s  = 1'b0;
    done_nxt_s  = 1'b0;
    skip_nxt_s  = 1'b0;
    error_nxt_s = 1'b0;
    valid_nxt_s = 1'b0;
    we_nxt_s    = 1'b0;
    addr_nxt_s  = {REG_ADDR_W{1'b0}};
    data_nxt_s  = {DATA_W{1'b0}};
    case (state_nxt_s)
      ST_DECODE, ST_WAIT_X, ST_WAIT_Y: busy_nxt_s = 1'b1;
      ST_REQ_X: begin
        busy_nxt_s  = 1'b1;
        valid_nxt_s = 1'b1;
        addr_nxt_s  = x_addr_s;
      end
      ST_REQ_Y: begin
        busy_nxt_s  = 1'b1;
        valid_nxt_s = 1'b1;
        addr_nxt_s  = y_addr_s;
      end
      ST_WR_RES: begin
        busy_nxt_s  = 1'b1;
        valid_nxt_s = 1'b1;
        we_nxt_s    = 1'b1;
        addr_nxt_s  = x_addr_s;
        data_nxt_s  = alu_res_s;
      end
      ST_WR_VF: begin
        busy_nxt_s  = 1'b1;
        valid_nxt_s = 1'b1;
        we_nxt_s    = 1'b1;
        addr_nxt_s  = VF_ADDR;
        data_nxt_s  = {{(DATA_W-1){1'b0}}, alu_flag_s};
      end
      ST_DONE: begin
        done_nxt_s  = 1'b1;
        error_nxt_s = (state_r == ST_IDLE);
        skip_nxt_s  = (state_r != ST_IDLE) && alu_skip_s;
      end
      default: busy_nxt_s = 1'b0;
    endcase
  end

  // Output registers
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_out      <= 1'b0;
      done_out      <= 1'b0;
      skip_out      <= 1'b0;
      error_out     <= 1'b0;
      reg_valid_out <= 1'b0;
      reg_we_out    <= 1'b0;
      reg_addr_out  <= {REG_ADDR_W{1'b0}};
      reg_data_out  <= {DATA_W{1'b0}};
    end else begin
      busy_out      <= busy_nxt_s;
      done_out      <= done_nxt_s;
      skip_out      <= skip_nxt_s;
      error_out     <= error_nxt_s;
      reg_valid_out <= valid_nxt_s;
      reg_we_out    <= we_nxt_s;
      reg_addr_out  <= addr_nxt_s;
      reg_data_out  <= data_nxt_s;
    end
  end

endmodule

// File: tb/tb_chip8_alu_unit.sv
// Directed bench for chip8_alu_unit with a register-memory responder (configurable ready and read latency).
module tb_chip8_alu_unit;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        start_in;
  logic [15:0] opcode_in;
  logic        busy_out, done_out, skip_out, error_out;
  logic [4:0]  reg_addr_out;
  logic        reg_we_out, reg_valid_out;
  logic [7:0]  reg_data_out;
  logic        reg_ready_in = 1'b1;
  logic        reg_valid_in = 1'b0;
  logic [7:0]  reg_data_in  = 8'h00;

  int checks = 0;
  int errors = 0;

  // responder configuration and preloaded register contents (written by tests only)
  logic [7:0] mem [0:31];
  int lat = 1;
  int ready_mode = 0;

  // responder state and logs (written by the responder only)
  int         cyc = 0;
  int         wr_cnt = 0;
  int         rd_acc = 0;
  int         valid_cnt = 0;
  int         stab_err = 0;
  int         pend_cnt = 0;
  logic [4:0] pend_addr = 5'd0;
  logic       stall_prev = 1'b0;
  logic [4:0] p_addr = 5'd0;
  logic       p_we = 1'b0;
  logic [7:0] p_data = 8'h00;
  logic [4:0] wr_addr_log [0:255];
  logic [7:0] wr_data_log [0:255];

  chip8_alu_unit dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .opcode_in(opcode_in),
    .busy_out(busy_out), .done_out(done_out), .skip_out(skip_out), .error_out(error_out),
    .reg_addr_out(reg_addr_out), .reg_we_out(reg_we_out), .reg_valid_out(reg_valid_out),
    .reg_data_out(reg_data_out), .reg_ready_in(reg_ready_in), .reg_valid_in(reg_valid_in),
    .reg_data_in(reg_data_in)
  );

  always #5 clk_in = ~clk_in;

  // Register-memory responder: accepts requests, returns reads after lat cycles, logs writes
  always @(posedge clk_in) begin
    cyc          <= cyc + 1;
    reg_valid_in <= 1'b0;
    reg_ready_in <= (ready_mode == 1) ? ~reg_ready_in : 1'b1;
    if (rst_in && reg_valid_out) valid_cnt <= valid_cnt + 1;
    if (rst_in && stall_prev &&
        (!reg_valid_out || reg_addr_out !== p_addr || reg_we_out !== p_we || reg_data_out !== p_data))
      stab_err <= stab_err + 1;
    stall_prev <= rst_in && reg_valid_out && !reg_ready_in;
    p_addr     <= reg_addr_out;
    p_we       <= reg_we_out;
    p_data     <= reg_data_out;
    if (pend_cnt > 0) begin
      if (pend_cnt == 1) begin
        reg_valid_in <= 1'b1;
        reg_data_in  <= mem[pend_addr];
      end
      pend_cnt <= pend_cnt - 1;
    end
    if (reg_valid_out && reg_ready_in) begin
      if (reg_we_out) begin
        wr_addr_log[wr_cnt[7:0]] <= reg_addr_out;
        wr_data_log[wr_cnt[7:0]] <= reg_data_out;
        wr_cnt <= wr_cnt + 1;
      end else begin
        rd_acc <= rd_acc + 1;
        if (lat <= 1) begin
          reg_valid_in <= 1'b1;
          reg_data_in  <= mem[reg_addr_out];
        end else begin
          pend_cnt  <= lat - 1;
          pend_addr <= reg_addr_out;
        end
      end
    end
  end

  // Pulse start for one cycle and wait (bounded) for done; latency -1 means done never came
  task automatic run_op(input logic [15:0] op, input int budget,
                        output int lat_o, output logic skip_o, output logic err_o);
    int  s;
    logic got;
    @(negedge clk_in);
    start_in  = 1'b1;
    opcode_in = op;
    s = cyc;
    @(negedge clk_in);
    start_in = 1'b0;
    got   = 1'b0;
    lat_o = -1;
    skip_o = 1'b0;
    err_o  = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      if (i > 0) @(negedge clk_in);
      if (done_out) begin
        got    = 1'b1;
        lat_o  = cyc - s;
        skip_o = skip_out;
        err_o  = error_out;
      end
    end
  endtask

  task automatic test_reset();
    rst_in    = 1'b0;
    start_in  = 1'b0;
    opcode_in = 16'h0000;
    repeat (3) @(negedge clk_in);
    checks++;
    if ({busy_out, done_out, skip_out, error_out, reg_valid_out, reg_we_out} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 000000",
               {busy_out, done_out, skip_out, error_out, reg_valid_out, reg_we_out});
    end
    checks++;
    if ({reg_addr_out, reg_data_out} !== 13'h0) begin
      errors++;
      $display("FAIL reset_bus got addr %0d data %h want 0 0", reg_addr_out, reg_data_out);
    end
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    checks++;
    if (busy_out !== 1'b0 || done_out !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got busy %b done %b want 0 0", busy_out, done_out);
    end
  endtask

  task automatic test_load();
    int l, wb;
    logic sk, er;
    wb = wr_cnt;
    run_op(16'h6A3C, 20, l, sk, er);
    checks++;
    if (l !== 3) begin errors++; $display("FAIL load_latency got %0d want 3", l); end
    checks++;
    if (sk !== 1'b0 || er !== 1'b0) begin
      errors++; $display("FAIL load_flags got skip %b err %b want 0 0", sk, er);
    end
    checks++;
    if (wr_cnt - wb !== 1) begin errors++; $display("FAIL load_wr_count got %0d want 1", wr_cnt - wb); end
    checks++;
    if (wr_addr_log[wb[7:0]] !== 5'd10 || wr_data_log[wb[7:0]] !== 8'h3C) begin
      errors++;
      $display("FAIL load_write got %0d:%h want 10:3c", wr_addr_log[wb[7:0]], wr_data_log[wb[7:0]]);
    end
  endtask

  task automatic test_add_sub();
    int l, wb;
    logic sk, er;
    mem[2] = 8'hF0;
    mem[3] = 8'h20;
    wb = wr_cnt;
    run_op(16'h8234, 40, l, sk, er);
    checks++;
    if (l !== 8) begin errors++; $display("FAIL add_latency got %0d want 8", l); end
    checks++;
    if (wr_cnt - wb !== 2) begin errors++; $display("FAIL add_wr_count got %0d want 2", wr_cnt - wb); end
    checks++;
    if (wr_addr_log[wb[7:0]] !== 5'd2 || wr_data_log[wb[7:0]] !== 8'h10 ||
        wr_addr_log[8'(wb + 1)] !== 5'd15 || wr_data_log[8'(wb + 1)] !== 8'h01) begin
      errors++;
      $display("FAIL add_writes got %0d:%h %0d:%h want 2:10 15:01", wr_addr_log[wb[7:0]],
               wr_data_log[wb[7:0]], wr_addr_log[8'(wb + 1)], wr_data_log[8'(wb + 1)]);
    end
    mem[2] = 8'h10;
    wb = wr_cnt;
    run_op(16'h8235, 40, l, sk, er);
    checks++;
    if (wr_cnt - wb !== 2 ||
        wr_addr_log[wb[7:0]] !== 5'd2 || wr_data_log[wb[7:0]] !== 8'hF0 ||
        wr_addr_log[8'(wb + 1)] !== 5'd15 || wr_data_log[8'(wb + 1)] !== 8'h00) begin
      errors++;
      $display("FAIL sub_writes got n=%0d %0d:%h %0d:%h want n=2 2:f0 15:00", wr_cnt - wb,
               wr_addr_log[wb[7:0]], wr_data_log[wb[7:0]], wr_addr_log[8'(wb + 1)], wr_data_log[8'(wb + 1)]);
    end
  endtask

  task automatic test_vf_dest();
    int l, wb;
    logic sk, er;
    mem[15] = 8'h81;
    wb = wr_cnt;
    run_op(16'h8FF6, 40, l, sk, er);
    checks++;
    if (wr_cnt - wb !== 2 ||
        wr_addr_log[wb[7:0]] !== 5'd15 || wr_data_log[wb[7:0]] !== 8'h40 ||
        wr_addr_log[8'(wb + 1)] !== 5'd15) begin
      errors++;
      $display("FAIL vf_dest_writes got n=%0d %0d:%h %0d want n=2 15:40 15", wr_cnt - wb,
               wr_addr_log[wb[7:0]], wr_data_log[wb[7:0]], wr_addr_log[8'(wb + 1)]);
    end
    checks++;
    if (wr_data_log[8'(wr_cnt - 1)] !== 8'h01) begin
      errors++; $display("FAIL vf_final got %h want 01", wr_data_log[8'(wr_cnt - 1)]);
    end
  endtask

  task automatic test_skip();
    int l, wb;
    logic sk, er;
    mem[5] = 8'h07;
    mem[6] = 8'h07;
    wb = wr_cnt;
    run_op(16'h3507, 40, l, sk, er);
    checks++;
    if (sk !== 1'b1 || l < 0) begin errors++; $display("FAIL skip_3xkk got %b want 1", sk); end
    checks++;
    if (wr_cnt !== wb) begin errors++; $display("FAIL skip_no_write got %0d writes want 0", wr_cnt - wb); end
    run_op(16'h4507, 40, l, sk, er);
    checks++;
    if (sk !== 1'b0 || l < 0) begin errors++; $display("FAIL skip_4xkk got %b want 0", sk); end
    run_op(16'h5560, 40, l, sk, er);
    checks++;
    if (sk !== 1'b1 || l < 0) begin errors++; $display("FAIL skip_5xy0 got %b want 1", sk); end
    run_op(16'h9560, 40, l, sk, er);
    checks++;
    if (sk !== 1'b0 || l < 0) begin errors++; $display("FAIL skip_9xy0 got %b want 0", sk); end
  endtask

  task automatic test_stall();
    int l, wb, sb;
    logic sk, er;
    ready_mode = 1;
    lat = 3;
    mem[12] = 8'hFE;
    wb = wr_cnt;
    sb = stab_err;
    run_op(16'h7C05, 60, l, sk, er);
    checks++;
    if (l < 0) begin errors++; $display("FAIL stall_done got timeout want done"); end
    checks++;
    if (wr_cnt - wb !== 1 || wr_addr_log[wb[7:0]] !== 5'd12 || wr_data_log[wb[7:0]] !== 8'h03) begin
      errors++;
      $display("FAIL stall_write got n=%0d %0d:%h want n=1 12:03", wr_cnt - wb,
               wr_addr_log[wb[7:0]], wr_data_log[wb[7:0]]);
    end
    checks++;
    if (stab_err !== sb) begin errors++; $display("FAIL stall_stable got %0d changes want 0", stab_err - sb); end
    ready_mode = 0;
    lat = 1;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic test_error();
    int l, vb;
    logic sk, er;
    vb = valid_cnt;
    run_op(16'hF00A, 20, l, sk, er);
    checks++;
    if (l !== 1 || er !== 1'b1) begin
      errors++; $display("FAIL err_F00A got lat %0d err %b want 1 1", l, er);
    end
    run_op(16'h8008, 20, l, sk, er);
    checks++;
    if (l !== 1 || er !== 1'b1) begin
      errors++; $display("FAIL err_8xy8 got lat %0d err %b want 1 1", l, er);
    end
    checks++;
    if (valid_cnt !== vb) begin errors++; $display("FAIL err_no_traffic got %0d want 0", valid_cnt - vb); end
  endtask

  task automatic test_reset_abort();
    int rb, wb, vb, l;
    logic found, sk, er;
    lat = 6;
    mem[1] = 8'h33;
    mem[2] = 8'h0F;
    rb = rd_acc;
    wb = wr_cnt;
    @(negedge clk_in);
    start_in  = 1'b1;
    opcode_in = 16'h8121;
    @(negedge clk_in);
    start_in = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (rd_acc - rb >= 2) found = 1'b1;
      else @(negedge clk_in);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL abort_reach_wait_y got %0d reads want 2", rd_acc - rb); end
    rst_in = 1'b0;
    #1;
    checks++;
    if ({busy_out, done_out, skip_out, error_out, reg_valid_out, reg_we_out, reg_addr_out, reg_data_out} !== 19'h0) begin
      errors++;
      $display("FAIL abort_outputs got busy %b valid %b addr %0d data %h want all 0",
               busy_out, reg_valid_out, reg_addr_out, reg_data_out);
    end
    vb = valid_cnt;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    repeat (12) @(negedge clk_in);
    checks++;
    if (wr_cnt !== wb || valid_cnt !== vb || busy_out !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet got writes %0d requests %0d busy %b want 0 0 0",
               wr_cnt - wb, valid_cnt - vb, busy_out);
    end
    lat = 1;
    run_op(16'h6A3C, 20, l, sk, er);
    checks++;
    if (l !== 3) begin errors++; $display("FAIL abort_recover got lat %0d want 3", l); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    test_reset();
    test_load();
    test_add_sub();
    test_vf_dest();
    test_skip();
    test_stall();
    test_error();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chip8_alu_unit.md
Name: chip8_alu_unit

Overview:
- Multi-cycle execute unit for the CHIP-8 register-class instructions: 3xkk, 4xkk, 5xy0, 6xkk, 7xkk, 8xy0–8xy7, 8xyE and 9xy0.
- Sits between the processor's decode stage and the shared register BRAM. All Vx/Vy/VF traffic uses a valid/ready request port plus a read-return strobe.
- Generalises the processor's inline 6xkk/7xkk handling to any data width and register count, and adds selectable quirk modes.

Parameters:
- DATA_W, 8, register data width.
- REG_ADDR_W, 5, width of the register-memory address.
- FLAG_REG, 15, register address used as VF.
- QUIRK_SHIFT_VY, 0, if 1 then 8xy6/8xyE shift Vy; if 0 they shift Vx.
- QUIRK_VF_RESET, 0, if 1 then 8xy1/2/3 also write VF=0.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset; one clock; reset is asynchronous and active-low.
- start_in  input  1  one-cycle pulse; accepted only when busy_out=0.
- opcode_in  input  16  instruction, sampled with start_in.
- busy_out  output  1  high from the cycle after an accepted start_in until done_out.
- done_out  output  1  one-cycle completion pulse.
- skip_out  output  1  valid with done_out; 1 means the caller advances pc by an extra 2.
- error_out  output  1  valid with done_out; 1 means the opcode is unsupported.
- reg_addr_out  output  REG_ADDR_W  request address.
- reg_we_out  output  1  1 for a write request, 0 for a read request.
- reg_valid_out  output  1  request valid.
- reg_data_out  output  DATA_W  write data.
- reg_ready_in  input  1  memory accepts the request this cycle.
- reg_valid_in  input  1  read data valid, at least 1 cycle after the request is accepted.
- reg_data_in  input  DATA_W  read data.

Behaviour:
- Reset (rst_in=0, asynchronous): state IDLE; all outputs 0. Reset mid-operation aborts immediately; no further requests are issued and pending read data is ignored.
- Request transfer: a request completes on a clock edge where reg_valid_out=1 and reg_ready_in=1. Until then, addr, we and data are held stable. Only one read is outstanding at a time.
- Addressing: x = opcode[11:8] and y = opcode[7:4], zero-extended to REG_ADDR_W. kk = opcode[7:0], zero-extended or truncated to DATA_W.
- States: IDLE → REQ_X → WAIT_X → REQ_Y → WAIT_Y → WR_RES → WR_VF → DONE. Opcodes skip the states they do not need.
- Per-opcode state paths:
  - 6xkk: WR_RES only.
  - 7xkk: X read, then WR_RES.
  - 3xkk/4xkk: X read, then DONE.
  - 5xy0/9xy0 and all 8xyN: X read and Y read.
- Decode: start_in in IDLE latches the opcode.
  - Unsupported opcode (any other first nibble, 5/9 with low nibble ≠0, 8 with low nibble in {8..D, F}): DONE on the next cycle with error_out=1 and no memory traffic.
- Arithmetic: all results are taken modulo 2^DATA_W.
  - 7xkk: Vx+kk; VF is untouched.
  - 8xy4: VF = carry out of bit DATA_W.
  - 8xy5: result Vx−Vy; VF = (Vx≥Vy).
  - 8xy7: result Vy−Vx; VF = (Vy≥Vx).
  - 8xy6: result src>>1; VF = src[0].
  - 8xyE: result src<<1; VF = src[DATA_W−1].
  - 8xy0: result Vy.
  - 8xy1/2/3: result OR/AND/XOR of Vx and Vy.
- Write ordering: the result write to x always precedes the VF write. If x=FLAG_REG, VF therefore ends holding the flag.
  - WR_VF is entered for 8xy4/5/6/7/E, and for 8xy1/2/3 only when QUIRK_VF_RESET=1.
- Skips: compare is Vx==kk (3), Vx!=kk (4), Vx==Vy (5), Vx!=Vy (9). skip_out is registered into DONE.
- DONE: lasts one cycle with done_out=1, then returns to IDLE. busy_out falls in the same cycle done_out rises. Any start_in while not IDLE is ignored.
- Latency, zero-wait memory (ready always 1, read data 1 cycle after acceptance):
  - 6xkk done at start+3.
  - 8xy4 done at start+8.

Test Plan:
- 6A3C, memory always ready → one write addr 10, data 0x3C; done_out 3 cycles after start; skip_out=0, error_out=0.
- V2=0xF0, V3=0x20, 8234 → writes V2=0x10, then VF=1; then 8235 with V2=0x10, V3=0x20 → V2=0xF0, VF=0.
- VF as destination: VF=0x81, 8FF6 (QUIRK_SHIFT_VY=0) → write VF=0x40, then VF=1; final VF=1.
- V5=0x07, 3507 → done with skip_out=1 and no writes; 4507 → skip_out=0; 5560 with V6=0x07 → skip_out=1.
- reg_ready_in toggling 0/1 every cycle with 3-cycle read latency, 7C05 with VC=0xFE → request held stable while not ready; final write 0x03; VF never written.
- F00A → done next cycle with error_out=1, reg_valid_out never high. Separately, assert rst_in=0 during WAIT_Y of 8xy1 → outputs 0 immediately, no write after release.
